// File: rtl/wallace_mul_pipe_if.sv
// Operand/result handshake bundle for wallace_mul_pipe.
// slave is the multiplier side, master the producer/consumer side.
interface wallace_mul_pipe_if #(
  parameter int WIDTH = 16,
  parameter int TAG_W = 4
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               signed_mode;
  logic [TAG_W-1:0]   in_tag;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] product;
  logic [TAG_W-1:0]   out_tag;

  modport slave (
    input  in_valid, a, b, signed_mode,
    input  in_tag, out_ready,
    output in_ready, out_valid,
    output product, out_tag
  );

  modport master (
    output in_valid, a, b, signed_mode,
    output in_tag, out_ready,
    input  in_ready, out_valid,
    input  product, out_tag
  );
endinterface

// File: rtl/wallace_mul_pipe.sv
// Pipelined Wallace-tree multiplier, unsigned or Baugh-Wooley signed.
// Global stall; CSA levels spread over the internal stages.
module wallace_mul_pipe #(
  parameter int WIDTH       = 16,
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 4
) (
  input logic               clk,
  input logic               rst_n,
  wallace_mul_pipe_if.slave bus
);
  localparam int PW = 2 * WIDTH;
  localparam int NR = WIDTH + 1;

  typedef logic [NR-1:0][PW-1:0] arr_t;

  function automatic int rows_at(int lvl);
    int n;
    n = NR;
    for (int i = 0; i < lvl; i++)
      if (n > 2) n = n - n / 3;
    return n;
  endfunction

  function automatic int nlev(int n0);
    int n;
    int c;
    n = n0;
    c = 0;
    for (int i = 0; i < 64; i++)
      if (n > 2) begin
        n = n - n / 3;
        c++;
      end
    return c;
  endfunction

  localparam int NL  = nlev(NR);
  localparam int NI  = PIPE_STAGES - 2;
  localparam int NID = (NI > 0) ? NI : 1;
  localparam int LLO = (NI > 0) ? NL : 0;

  // Row WIDTH carries the Baugh-Wooley correction constant.
  function automatic arr_t ppgen(
    logic [WIDTH-1:0] x,
    logic [WIDTH-1:0] y,
    logic             sm
  );
    arr_t r;
    logic t;
    r = '0;
    for (int i = 0; i < WIDTH; i++)
      for (int j = 0; j < WIDTH; j++) begin
        t = x[j] & y[i];
        if (sm && ((i == WIDTH-1) != (j == WIDTH-1)))
          t = ~t;
        r[i][i+j] = t;
      end
    if (sm) begin
      r[WIDTH][WIDTH] = 1'b1;
      r[WIDTH][PW-1]  = 1'b1;
    end
    return r;
  endfunction

  function automatic arr_t reduce(arr_t r, int lo, int hi);
    arr_t x;
    arr_t y;
    int   n;
    int   g;
    x = r;
    for (int l = 0; l < NL; l++)
      if (l >= lo && l < hi) begin
        n = rows_at(l);
        g = n / 3;
        y = '0;
        for (int i = 0; i < NR / 3; i++)
          if (i < g) begin
            y[2*i]   = x[3*i] ^ x[3*i+1] ^ x[3*i+2];
            y[2*i+1] = ((x[3*i] & x[3*i+1]) |
                        (x[3*i] & x[3*i+2]) |
                        (x[3*i+1] & x[3*i+2])) << 1;
          end
        for (int k = 0; k < 2; k++)
          if (k < n % 3) y[2*g+k] = x[3*g+k];
        x = y;
      end
    return x;
  endfunction

  function automatic logic [PW-1:0] finish(arr_t r, int lo);
    arr_t x;
    x = reduce(r, lo, NL);
    return x[0] + x[1];
  endfunction

  logic             stall;
  logic             v  [PIPE_STAGES];
  logic [TAG_W-1:0] tg [PIPE_STAGES];
  logic [PW-1:0]    prod_q;

  assign stall         = v[PIPE_STAGES-1] & ~bus.out_ready;
  assign bus.in_ready  = ~stall;
  assign bus.out_valid = v[PIPE_STAGES-1];
  assign bus.out_tag   = tg[PIPE_STAGES-1];
  assign bus.product   = prod_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < PIPE_STAGES; k++) begin
        v[k]  <= 1'b0;
        tg[k] <= '0;
      end
    end else if (!stall) begin
      v[0] <= bus.in_valid;
      if (bus.in_valid) tg[0] <= bus.in_tag;
      for (int k = 1; k < PIPE_STAGES; k++) begin
        v[k] <= v[k-1];
        if (v[k-1]) tg[k] <= tg[k-1];
      end
    end
  end

  generate
    if (PIPE_STAGES == 1) begin : g_one
      logic [PW-1:0] sum;

      always_comb
        sum = finish(ppgen(bus.a, bus.b, bus.signed_mode), 0);

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
          prod_q <= '0;
        else if (!stall && bus.in_valid)
          prod_q <= sum;
      end
    end else begin : g_multi
      arr_t          rq [PIPE_STAGES-1];
      arr_t          nx [PIPE_STAGES-1];
      logic [PW-1:0] sum;

      always_comb begin
        nx[0] = ppgen(bus.a, bus.b, bus.signed_mode);
        for (int k = 1; k < PIPE_STAGES-1; k++)
          nx[k] = reduce(rq[k-1],
                         ((k-1) * NL) / NID,
                         (k * NL) / NID);
        sum = finish(rq[PIPE_STAGES-2], LLO);
      end

      // Data only moves with a valid op so bubbles leave it untouched.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int k = 0; k < PIPE_STAGES-1; k++)
            rq[k] <= '0;
          prod_q <= '0;
        end else if (!stall) begin
          if (bus.in_valid) rq[0] <= nx[0];
          for (int k = 1; k < PIPE_STAGES-1; k++)
            if (v[k-1]) rq[k] <= nx[k];
          if (v[PIPE_STAGES-2]) prod_q <= sum;
        end
      end
    end
  endgenerate
endmodule

// File: tb/tb_wallace_mul_pipe.sv
// Scoreboard bench for wallace_mul_pipe: directed corners,
// backpressure, mid-flight reset and random traffic.
module tb_wallace_mul_pipe;
  parameter int W  = 16;
  parameter int PS = 3;
  parameter int TW = 4;
  localparam int PW = 2 * W;

  typedef struct {
    logic [63:0]   prod;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;
  int   rdy_mode = 0;
  bit   rdy_force = 1'b1;
  exp_t sb [$];

  wallace_mul_pipe_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  wallace_mul_pipe #(
    .WIDTH(W), .PIPE_STAGES(PS), .TAG_W(TW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [PW-1:0] model(
    logic [W-1:0] x, logic [W-1:0] y, logic sm
  );
    longint px;
    longint py;
    px = longint'(x);
    py = longint'(y);
    if (sm && x[W-1]) px = px - (longint'(1) << W);
    if (sm && y[W-1]) py = py - (longint'(1) << W);
    return PW'(px * py);
  endfunction

  function automatic logic [63:0] pick(
    logic [63:0] c, logic [W-1:0] x,
    logic [W-1:0] y, logic sm
  );
    return (W == 16) ? c : 64'(model(x, y, sm));
  endfunction

  task automatic chk(
    string nm, logic [63:0] act, logic [63:0] exp
  );
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ($urandom_range(0, 9) < 7);
        default: bus.out_ready = rdy_force;
      endcase
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("in_ready", 64'(bus.in_ready),
          64'(!(bus.out_valid && !bus.out_ready)));
      if (bus.out_valid) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL spurious: tag %0d product %h, none due",
                   bus.out_tag, bus.product);
        end else begin
          chk("product", 64'(bus.product), sb[0].prod);
          chk("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
          if (bus.out_ready) begin
            if (sb[0].lat)
              chk("latency", 64'(cyc - sb[0].acc), 64'(PS - 1));
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  task automatic send(
    input logic [W-1:0] x, input logic [W-1:0] y,
    input logic sm, input logic [TW-1:0] t,
    input logic [63:0] e
  );
    int tries = 0;
    bit acc = 1'b0;
    bit m0  = (rdy_mode == 0);
    while (!acc && tries < 200) begin
      bus.in_valid    = 1'b1;
      bus.a           = x;
      bus.b           = y;
      bus.signed_mode = sm;
      bus.in_tag      = t;
      @(negedge clk);
      acc = bus.in_ready;
      if (!acc) begin
        bus.in_valid    = 1'($urandom_range(0, 1));
        bus.a           = W'($urandom);
        bus.b           = W'($urandom);
        bus.signed_mode = 1'($urandom);
        bus.in_tag      = TW'($urandom);
      end
      @(posedge clk);
      #1;
      if (!acc) tries++;
    end
    if (m0) chk("no_wait_accept", 64'(tries), 64'd0);
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL accept_timeout: tag %0d never accepted", t);
    end else begin
      sb.push_back('{prod: e, tag: t, acc: cyc,
                     lat: (rdy_mode == 0)});
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(int n);
    bus.in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 500) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain", 64'(sb.size()), 64'd0);
    idle(3);
  endtask

  task automatic send_rand();
    logic [W-1:0]  x;
    logic [W-1:0]  y;
    logic          sm;
    logic [TW-1:0] t;
    x  = W'($urandom);
    y  = W'($urandom);
    sm = 1'($urandom);
    t  = TW'($urandom);
    if ($urandom_range(0, 15) == 0) x = '1;
    if ($urandom_range(0, 15) == 0) y = '0;
    send(x, y, sm, t, 64'(model(x, y, sm)));
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] msb;
    int nfl;
    ones = '1;
    msb = '0;
    msb[W-1] = 1'b1;
    nfl = (PS < 3) ? PS : 3;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.signed_mode = 1'b0;
    bus.in_tag = '0;
    rst_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_product", 64'(bus.product), 64'd0);
    chk("rst_out_tag", 64'(bus.out_tag), 64'd0);
    #21 rst_n = 1'b1;
    @(posedge clk);
    #1;

    send(ones, ones, 1'b0, TW'(5),
         pick(64'hFFFE0001, ones, ones, 1'b0));
    send('0, W'(16'h1234), 1'b0, TW'(1), 64'd0);
    send(msb, msb, 1'b1, TW'(2),
         pick(64'h40000000, msb, msb, 1'b1));
    send(ones, W'(3), 1'b1, TW'(3),
         pick(64'hFFFFFFFD, ones, W'(3), 1'b1));
    send(~msb, msb, 1'b1, TW'(4),
         pick(64'hC0008000, ~msb, msb, 1'b1));
    drain();

    for (int i = 0; i < 8; i++) begin
      logic [W-1:0] x;
      logic [W-1:0] y;
      x = W'($urandom);
      y = W'($urandom);
      send(x, y, 1'(i), TW'(i), 64'(model(x, y, 1'(i))));
    end
    drain();

    rdy_mode = 2;
    rdy_force = 1'b1;
    idle(1);
    fork
      begin
        for (int i = 0; i < 5; i++) send_rand();
      end
      begin
        int n = 0;
        while (!bus.out_valid && n < 50) begin
          @(negedge clk);
          n++;
        end
        rdy_force = 1'b0;
        repeat (4) @(posedge clk);
        rdy_force = 1'b1;
      end
    join
    drain();

    rdy_force = 1'b0;
    idle(2);
    for (int i = 0; i < nfl; i++) send_rand();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(bus.out_valid), 64'd0);
    chk("mid_rst_product", 64'(bus.product), 64'd0);
    chk("mid_rst_tag", 64'(bus.out_tag), 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    rdy_mode = 0;
    idle(2);
    send_rand();
    drain();
    idle(8);

    rdy_mode = 1;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      send_rand();
    end
    drain();
    rdy_mode = 0;
    idle(2);
    for (int i = 0; i < 300; i++) send_rand();
    drain();

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/wallace_mul_pipe.md
Name: wallace_mul_pipe

Overview:
- Parametrised, pipelined successor to the team's fixed 16x16 combinational Wallace-tree multiplier.
- Multiplies two WIDTH-bit operands, unsigned or two's-complement selected per transaction. The partial-product array is reduced by 3:2 carry-save levels, and the final carry-propagate add is registered.
- Pipeline registers sit between reduction levels, and valid/ready handshakes on both sides let the block drop into the datapath between an operand FIFO and a writeback stage.

Parameters:
- WIDTH, 16, operand width in bits (min 4, max 32); product is 2*WIDTH bits.
- PIPE_STAGES, 3, number of register stages = input-to-output latency in cycles (min 1, max 6); stage 1 always registers operands plus partial products, the last stage always registers the final CPA sum.
- TAG_W, 4, width of a sideband tag carried alongside each operation.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair present
- in_ready  output  1  block accepts operands this cycle
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = two's-complement operands, 0 = unsigned
- in_tag  input  TAG_W  sideband tag, returned unchanged with the result
- out_valid  output  1  product present
- out_ready  input  1  consumer accepts product this cycle
- product  output  2*WIDTH  a*b result
- out_tag  output  TAG_W  tag of the returned product

Behaviour:
- Reset (rst_n low, asynchronous): every stage valid bit cleared, so out_valid=0 immediately. Data/tag registers reset to 0, so product=0 and out_tag=0. in_ready=1 while reset is deasserted and the pipe is not stalled. Reset mid-operation discards all in-flight operations; no result is emitted for them.
- Accept: an operation is accepted on a rising edge when in_valid && in_ready.
- Deliver: a result is delivered on a rising edge when out_valid && out_ready.
- Stall: the pipeline uses a global stall, stall = out_valid && !out_ready.
  - in_ready = !stall.
  - While stalled, no stage register changes: product and out_tag stay stable and out_valid stays 1.
  - Bubbles are not collapsed.
- Latency: with out_ready held 1, an operation accepted at edge N appears with out_valid=1 after edge N+PIPE_STAGES-1, i.e. it is visible for the cycle following that edge. PIPE_STAGES=1 gives operand-register-to-output in one edge. Throughput is 1 operation/cycle with no stalls.
- Invalid stages advance normally when not stalled; a bubble never raises out_valid.
- Partial products:
  - Unsigned mode: row i = b[i] ? a<<i : 0, zero-extended to 2*WIDTH.
  - Signed mode: Baugh-Wooley form. Complement the MSB-crossing terms and add the constant 1<<WIDTH plus 1<<(2*WIDTH-1), all modulo 2^(2*WIDTH).
  - Signed mode is sampled with the operands and travels down the pipe with them.
- Reduction: 3:2 CSA levels, reducing rows floor(n/3)*3 per level with leftovers passed through, until two rows remain. Those two rows go to a ripple/prefix CPA. The carry-out of the CPA is discarded; the result is exact in 2*WIDTH bits.
- Register placement: the reduction levels are split evenly across PIPE_STAGES-2 internal stages. Extra stages beyond the level count are plain delay registers. Functional latency is PIPE_STAGES regardless of placement.
- Arithmetic contract: product == a*b exactly, interpreted unsigned or signed per signed_mode. A signed result is valid two's-complement across all 2*WIDTH bits.
- Simultaneous accept and deliver in the same cycle is legal and keeps full throughput.
- Changing in_valid, a, b or tag while in_ready=0 has no effect.
- No combinational path from in_valid or a/b to any output. in_ready depends combinationally only on out_ready and internal state.

Test Plan:
- Unsigned corners, WIDTH=16, PIPE_STAGES=3, out_ready=1:
  - a=0xFFFF, b=0xFFFF, tag=5 -> product=0xFFFE0001, out_tag=5, exactly 3 edges after accept.
  - a=0, b=0x1234 -> product=0.
- Signed corners, signed_mode=1:
  - a=0x8000, b=0x8000 -> 0x40000000.
  - a=0xFFFF(-1), b=0x0003 -> 0xFFFFFFFD.
  - a=0x7FFF, b=0x8000 -> 0xC0008000.
- Streaming with mixed modes, b2b: issue 8 back-to-back ops alternating signed_mode, tags 0..7 -> 8 consecutive out_valid cycles, results and tags in order, in_ready never drops.
- Backpressure:
  - Stream 5 ops, hold out_ready=0 for 4 cycles once out_valid rises -> product/out_tag frozen, in_ready=0 during the stall.
  - After release, all 5 results delivered in order with none lost or duplicated.
- Reset mid-flight: assert rst_n=0 asynchronously (between edges) with 3 ops in flight -> out_valid=0 and product=0 immediately. After release, the next op's result is the only output; no stale results appear.
- Parameter sweep, randomized vs. reference model (10k ops each, random out_ready):
  - WIDTH in {4, 8, 32}, PIPE_STAGES in {1, 6}.
  - Required: zero mismatches, latency == PIPE_STAGES when unstalled.
  - WIDTH=4 signed: -8*-8 -> 0x40.
